// File: rtl/addr_gen_pkg.sv
// Shared types and width helpers for the h/c address sequencer.
// Latency: n/a (types, constants and a function only).
// Backpressure: n/a.
package addr_gen_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SWEEP = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Counter width for a range of n values; never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Default geometry and the counter widths it implies
  localparam int NUM_CELLS_DEF = 53;
  localparam int TIMESTEP_DEF  = 7;
  localparam int DELAY_DEF     = 1;
  localparam int K_W_DEF       = cnt_w(NUM_CELLS_DEF);
  localparam int T_W_DEF       = cnt_w(TIMESTEP_DEF);
  localparam int D_W_DEF       = cnt_w(DELAY_DEF + 1);

endpackage

// File: rtl/addr_gen_hc_seq_mod_counter.sv
// Wrapping 0..MAX counter with clear/enable, optional count-down, terminal flag.
// Latency: count updates one cycle after inc; tc is combinational from the count.
// Backpressure: none; inc low holds the count.
module mod_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic             dn,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX);

  logic [WIDTH-1:0] cnt_q;

  // Clear loads the first value for the chosen direction; inc steps and wraps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= dn ? TOP : '0;
    end else if (inc) begin
      if (dn) cnt_q <= (cnt_q == '0) ? TOP : cnt_q - WIDTH'(1);
      else    cnt_q <= (cnt_q == TOP) ? '0 : cnt_q + WIDTH'(1);
    end
  end

  assign cnt = cnt_q;
  assign tc  = dn ? (cnt_q == '0) : (cnt_q == TOP);

endmodule

// File: rtl/addr_gen_hc_seq.sv
// h/c RAM address sequencer: per timestep/cell, sweep neighbour h row, wait, write once. ADDR_GEN_HC_BWD_EN enables backward order.
// Latency: SWEEP from the edge that samples start; NUM_CELLS+DELAY+1 cycles per cell, one DONE cycle per run.
// Backpressure: en low freezes all state; strobes drop and the stalled beat is reissued when en returns.
module addr_gen_hc_seq
  import addr_gen_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_CELLS  = 53,
  parameter int TIMESTEP   = 7,
  parameter int DELAY      = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        dir,
  input  logic                        en,
  output logic [ADDR_WIDTH-1:0]       o_addr_h,
  output logic [ADDR_WIDTH-1:0]       o_addr_c,
  output logic                        o_h_vld,
  output logic                        o_h_zero,
  output logic                        o_wr,
  output logic [cnt_w(TIMESTEP)-1:0]  o_step,
  output logic                        o_busy,
  output logic                        o_done
);

  localparam int K_W   = cnt_w(NUM_CELLS);
  localparam int T_W   = cnt_w(TIMESTEP);
  localparam int D_W   = cnt_w(DELAY + 1);
  localparam int D_MAX = (DELAY > 0) ? DELAY - 1 : 0;
  localparam logic [ADDR_WIDTH-1:0] NC_A = ADDR_WIDTH'(NUM_CELLS);

  state_t state_q, state_d;

  logic [K_W-1:0] k_cnt;
  logic [K_W-1:0] cell_cnt;
  logic [T_W-1:0] t_cnt;
  logic [D_W-1:0] dly_cnt_unused;
  logic           k_tc, cell_tc, t_tc, dly_tc;

  logic                  first_q;   // current step is the first in run order
  logic [ADDR_WIDTH-1:0] base_q;    // row(t)
  logic [ADDR_WIDTH-1:0] nbase_q;   // row of the previous step in run order
  logic                  go;
  logic                  step_adv;
  logic                  t_dn;

  assign go       = (state_q == IDLE) & start & en;
  assign step_adv = en & (state_q == WRITE) & cell_tc & ~t_tc;

`ifdef ADDR_GEN_HC_BWD_EN
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'((TIMESTEP - 1) * NUM_CELLS);
  logic dir_q;
  // While idle the t counter must see the incoming dir so clear loads the right end
  assign t_dn = (state_q == IDLE) ? dir : dir_q;
`else
  logic unused_dir;
  assign unused_dir = dir;
  assign t_dn       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; nothing moves while en is low
  always_comb begin
    state_d = state_q;
    if (en) begin
      case (state_q)
        IDLE:    if (start) state_d = SWEEP;
        SWEEP:   if (k_tc) state_d = (DELAY == 0) ? WRITE : WAIT;
        WAIT:    if (dly_tc) state_d = WRITE;
        WRITE:   state_d = (cell_tc && t_tc) ? DONE : SWEEP;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Row bases: nbase trails base by one step so the neighbour row needs no adder per direction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_q <= 1'b0;
      base_q  <= '0;
      nbase_q <= '0;
`ifdef ADDR_GEN_HC_BWD_EN
      dir_q   <= 1'b0;
`endif
    end else if (go) begin
      first_q <= 1'b1;
      nbase_q <= '0;
`ifdef ADDR_GEN_HC_BWD_EN
      dir_q   <= dir;
      base_q  <= dir ? LAST_ROW : '0;
`else
      base_q  <= '0;
`endif
    end else if (step_adv) begin
      first_q <= 1'b0;
      nbase_q <= base_q;
`ifdef ADDR_GEN_HC_BWD_EN
      base_q  <= dir_q ? base_q - NC_A : base_q + NC_A;
`else
      base_q  <= base_q + NC_A;
`endif
    end
  end

  // Sweep index k over the neighbour h row
  mod_counter #(.WIDTH(K_W), .MAX(NUM_CELLS - 1)) u_k (
    .clk (clk), .rst (rst),
    .inc (en & (state_q == SWEEP)), .clr (go), .dn (1'b0),
    .cnt (k_cnt), .tc (k_tc)
  );

  // Current cell; wraps to 0 on the last write of a step
  mod_counter #(.WIDTH(K_W), .MAX(NUM_CELLS - 1)) u_cell (
    .clk (clk), .rst (rst),
    .inc (en & (state_q == WRITE)), .clr (go), .dn (1'b0),
    .cnt (cell_cnt), .tc (cell_tc)
  );

  // Timestep index; tc marks the last step in run order
  mod_counter #(.WIDTH(T_W), .MAX(TIMESTEP - 1)) u_t (
    .clk (clk), .rst (rst),
    .inc (step_adv), .clr (go), .dn (t_dn),
    .cnt (t_cnt), .tc (t_tc)
  );

  // Pipeline delay between sweep end and write
  mod_counter #(.WIDTH(D_W), .MAX(D_MAX)) u_dly (
    .clk (clk), .rst (rst),
    .inc (en & (state_q == WAIT)), .clr (go), .dn (1'b0),
    .cnt (dly_cnt_unused), .tc (dly_tc)
  );

  // Outputs decoded from registered state; zero whenever not running
  always_comb begin
    o_addr_h = '0;
    o_addr_c = '0;
    o_h_zero = 1'b0;
    o_step   = '0;
    o_busy   = (state_q == SWEEP) || (state_q == WAIT) || (state_q == WRITE);
    o_h_vld  = (state_q == SWEEP) & en;
    o_wr     = (state_q == WRITE) & en;
    o_done   = (state_q == DONE) & en;
    if (o_busy) begin
      o_addr_c = base_q + ADDR_WIDTH'(cell_cnt);
      o_step   = t_cnt;
      o_h_zero = first_q;
    end
    if (state_q == SWEEP) begin
      o_addr_h = first_q ? ADDR_WIDTH'(k_cnt) : nbase_q + ADDR_WIDTH'(k_cnt);
    end
  end

endmodule

// File: tb/tb_addr_gen_hc_seq.sv
// Directed bench for addr_gen_hc_seq with NUM_CELLS=3, TIMESTEP=2 (DELAY=1 and DELAY=0 instances).
// Latency: n/a.
// Backpressure: exercises en stalls mid-sweep.
module tb_addr_gen_hc_seq;

  logic clk, rst, start, start0, dir, en;

  logic [11:0] o_addr_h, o_addr_c;
  logic        o_h_vld, o_h_zero, o_wr, o_busy, o_done;
  logic [0:0]  o_step;

  logic [11:0] z_addr_h, z_addr_c;
  logic        z_h_vld, z_h_zero, z_wr, z_busy, z_done;
  logic [0:0]  z_step;

  addr_gen_hc_seq #(.ADDR_WIDTH(12), .NUM_CELLS(3), .TIMESTEP(2), .DELAY(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .en(en),
    .o_addr_h(o_addr_h), .o_addr_c(o_addr_c), .o_h_vld(o_h_vld), .o_h_zero(o_h_zero),
    .o_wr(o_wr), .o_step(o_step), .o_busy(o_busy), .o_done(o_done)
  );

  addr_gen_hc_seq #(.ADDR_WIDTH(12), .NUM_CELLS(3), .TIMESTEP(2), .DELAY(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .dir(dir), .en(en),
    .o_addr_h(z_addr_h), .o_addr_c(z_addr_c), .o_h_vld(z_h_vld), .o_h_zero(z_h_zero),
    .o_wr(z_wr), .o_step(z_step), .o_busy(z_busy), .o_done(z_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic            dir;
    logic            stall;
    logic [1:0][11:0] crow;   // row(t) per run-order step
    logic [1:0][11:0] hrow;   // neighbour row per run-order step
    logic [1:0]      zero;
    logic [1:0]      step;
    logic [31:0]     busy;
  } vec_t;

  typedef struct packed { logic [11:0] h; logic [11:0] c; logic z; logic s; } hrec_t;
  typedef struct packed { logic [11:0] c; logic s; } wrec_t;
  typedef struct packed { logic [31:0] t; logic [11:0] c; } zrec_t;

  hrec_t hq[$];
  wrec_t wq[$];
  zrec_t zq[$];
  int    busy_n, done_n, busy0_n, done0_n, cyc;
  logic  mon_clr, mon0_clr;
  int    checks, errors;

  vec_t vt[4];

  // Trace capture away from the active edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mon_clr) begin
      hq.delete(); wq.delete(); busy_n = 0; done_n = 0;
    end else begin
      if (o_h_vld) hq.push_back({o_addr_h, o_addr_c, o_h_zero, o_step[0]});
      if (o_wr)    wq.push_back({o_addr_c, o_step[0]});
      if (o_busy)  busy_n = busy_n + 1;
      if (o_done)  done_n = done_n + 1;
    end
    if (mon0_clr) begin
      zq.delete(); busy0_n = 0; done0_n = 0;
    end else begin
      if (z_wr)   zq.push_back({cyc[31:0], z_addr_c});
      if (z_busy) busy0_n = busy0_n + 1;
      if (z_done) done0_n = done0_n + 1;
    end
  end

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk(nm, 0, {o_addr_h, o_addr_c}, 32'd0);
    chk(nm, 1, {27'd0, o_h_vld, o_h_zero, o_wr, o_busy, o_done}, 32'd0);
    chk(nm, 2, {31'd0, o_step}, 32'd0);
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    int n;
    int s, cl, k;
    @(posedge clk); #1 mon_clr = 1'b1; dir = v.dir;
    @(posedge clk); #1 mon_clr = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0; dir = ~v.dir;
    if (v.stall) begin
      @(posedge clk); #1 en = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk); #1;
        chk("stall_vld", i, {31'd0, o_h_vld}, 32'd0);
        chk("stall_addr_h", i, {20'd0, o_addr_h}, 32'd1);
        @(posedge clk);
      end
      #1 en = 1'b1;
    end
    n = 0;
    while (done_n == 0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk("done_timeout", vi, {31'd0, n >= 200}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("done_count", vi, done_n, 32'd1);
    chk("busy_cycles", vi, busy_n, v.busy);
    chk("h_beats", vi, hq.size(), 32'd18);
    chk("wr_beats", vi, wq.size(), 32'd6);
    for (int i = 0; i < 18; i++) begin
      s = i / 9; cl = (i / 3) % 3; k = i % 3;
      if (i < hq.size())
        chk("h_trace", vi * 100 + i, {6'd0, hq[i]},
            {6'd0, v.hrow[s] + 12'(k), v.crow[s] + 12'(cl), v.zero[s], v.step[s]});
    end
    for (int i = 0; i < 6; i++) begin
      s = i / 3; cl = i % 3;
      if (i < wq.size())
        chk("wr_trace", vi * 100 + i, {19'd0, wq[i]}, {19'd0, v.crow[s] + 12'(cl), v.step[s]});
    end
    dir = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    checks = 0; errors = 0; cyc = 0;
    busy_n = 0; done_n = 0; busy0_n = 0; done0_n = 0;
    mon_clr = 1'b1; mon0_clr = 1'b1;
    rst = 1'b0; start = 1'b0; start0 = 1'b0; dir = 1'b0; en = 1'b1;

    // forward: rows 0 then 3, neighbour zero then row 0
    vt[0] = {1'b0, 1'b0, {12'd3, 12'd0}, {12'd0, 12'd0}, 2'b01, 2'b10, 32'd30};
`ifdef ADDR_GEN_HC_BWD_EN
    // backward: step 1 (row 3) first with zero neighbour, then step 0 reading row 3
    vt[1] = {1'b1, 1'b0, {12'd0, 12'd3}, {12'd3, 12'd0}, 2'b01, 2'b01, 32'd30};
`else
    vt[1] = {1'b1, 1'b0, {12'd3, 12'd0}, {12'd0, 12'd0}, 2'b01, 2'b10, 32'd30};
`endif
    // forward with a 4-cycle stall at k=1
    vt[2] = {1'b0, 1'b1, {12'd3, 12'd0}, {12'd0, 12'd0}, 2'b01, 2'b10, 32'd34};
    vt[3] = vt[0];

    repeat (2) @(posedge clk);
    #1 chk_idle_outputs("reset");
    rst = 1'b1;
    @(posedge clk); #1 mon_clr = 1'b0; mon0_clr = 1'b0;
    chk_idle_outputs("idle_after_reset");

    for (int i = 0; i < 3; i++) run_vec(i, vt[i]);

    // reset during WAIT of step 1
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!(o_busy && o_step == 1'b1 && !o_h_vld && !o_wr) && n < 100);
    chk("wait_step1_timeout", 0, {31'd0, n >= 100}, 32'd0);
    rst = 1'b0;
    #1 chk_idle_outputs("mid_reset");
    @(posedge clk); #1 chk_idle_outputs("mid_reset_hold");
    rst = 1'b1;
    run_vec(3, vt[3]);

    // DELAY=0 instance: 4-cycle cell period, start while busy ignored
    @(posedge clk); #1 mon0_clr = 1'b1;
    @(posedge clk); #1 mon0_clr = 1'b0; start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    repeat (5) @(posedge clk);
    #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    n = 0;
    while (done0_n == 0 && n < 200) begin
      @(negedge clk); #1; n++;
    end
    chk("d0_timeout", 0, {31'd0, n >= 200}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("d0_done_count", 0, done0_n, 32'd1);
    chk("d0_busy_cycles", 0, busy0_n, 32'd24);
    chk("d0_wr_beats", 0, zq.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < zq.size()) begin
        chk("d0_wr_addr", i, {20'd0, zq[i].c}, 32'(i));
        if (i > 0) chk("d0_period", i, zq[i].t - zq[i-1].t, 32'd4);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
